// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - M:SS BCD game countdown clock prescaled from frame ticks
module countdown_timer #(
    parameter int TICKS_PER_SEC = 60,
    parameter int SUB_W         = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        load,
    input  logic [11:0] load_bcd,
    input  logic        start,
    input  logic        pause,
    output logic [11:0] time_bcd,
    output logic        running,
    output logic        done,
    output logic        expired
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);

    state_t           state, state_nx;
    logic [SUB_W-1:0] sub, sub_nx;
    logic [11:0]      time_nx;
    logic [11:0]      clamped;
    logic [11:0]      dec;
    logic             expired_nx;

    assign clamped[11:8] = (load_bcd[11:8] > 4'd9) ? 4'd9 : load_bcd[11:8];
    assign clamped[7:4]  = (load_bcd[7:4]  > 4'd5) ? 4'd5 : load_bcd[7:4];
    assign clamped[3:0]  = (load_bcd[3:0]  > 4'd9) ? 4'd9 : load_bcd[3:0];

    // One-second BCD decrement with borrows ripple ones -> tens -> minutes
    always_comb begin
        dec = time_bcd;
        if (time_bcd != 12'h000) begin
            if (time_bcd[3:0] != 4'd0) begin
                dec[3:0] = time_bcd[3:0] - 4'd1;
            end else begin
                dec[3:0] = 4'd9;
                if (time_bcd[7:4] != 4'd0) begin
                    dec[7:4] = time_bcd[7:4] - 4'd1;
                end else begin
                    dec[7:4]  = 4'd5;
                    dec[11:8] = time_bcd[11:8] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_nx   = state;
        time_nx    = time_bcd;
        sub_nx     = sub;
        expired_nx = 1'b0;
        if (load) begin
            time_nx  = clamped;
            sub_nx   = '0;
            state_nx = IDLE;
        end else if (pause && state == RUN) begin
            state_nx = PAUSED;
        end else if (start && (state == IDLE || state == PAUSED) && time_bcd != 12'h000) begin
            state_nx = RUN;
        end else if (tick && state == RUN) begin
            if (sub == SUB_LAST) begin
                sub_nx  = '0;
                time_nx = dec;
                if (dec == 12'h000) begin
                    state_nx   = DONE;
                    expired_nx = 1'b1;
                end
            end else begin
                sub_nx = sub + SUB_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            time_bcd <= 12'h000;
            sub      <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
            expired  <= 1'b0;
        end else begin
            state    <= state_nx;
            time_bcd <= time_nx;
            sub      <= sub_nx;
            running  <= (state_nx == RUN);
            done     <= (state_nx == DONE);
            expired  <= expired_nx;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed bench with a seconds-based reference model
module tb_countdown_timer;

    localparam int TPS = 60;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        load = 1'b0;
    logic [11:0] load_bcd = 12'h000;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [11:0] time_bcd;
    logic        running;
    logic        done;
    logic        expired;

    int total  = 0;
    int passed = 0;

    countdown_timer #(.TICKS_PER_SEC(TPS), .SUB_W(6)) dut (
        .clock(clock), .reset(reset), .tick(tick), .load(load), .load_bcd(load_bcd),
        .start(start), .pause(pause), .time_bcd(time_bcd), .running(running),
        .done(done), .expired(expired)
    );

    always #5 clock = ~clock;

    // Model: remaining time as total seconds, mode 0 idle / 1 run / 2 paused / 3 done
    int m_secs = 0;
    int m_sub  = 0;
    int m_mode = 0;
    bit m_exp  = 1'b0;

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    always @(posedge clock or posedge reset) begin : model
        int s, sb, md;
        bit ex;
        if (reset) begin
            m_secs <= 0; m_sub <= 0; m_mode <= 0; m_exp <= 1'b0;
        end else begin
            s = m_secs; sb = m_sub; md = m_mode; ex = 1'b0;
            if (load) begin
                s  = min_i(int'(load_bcd[11:8]), 9) * 60 + min_i(int'(load_bcd[7:4]), 5) * 10
                   + min_i(int'(load_bcd[3:0]), 9);
                sb = 0; md = 0;
            end else if (pause && md == 1) begin
                md = 2;
            end else if (start && (md == 0 || md == 2) && s != 0) begin
                md = 1;
            end else if (tick && md == 1) begin
                sb = sb + 1;
                if (sb == TPS) begin
                    sb = 0;
                    s  = s - 1;
                    if (s == 0) begin
                        md = 3; ex = 1'b1;
                    end
                end
            end
            m_secs <= s; m_sub <= sb; m_mode <= md; m_exp <= ex;
        end
    end

    function automatic logic [11:0] to_bcd(input int secs);
        return {4'(secs / 60), 4'((secs % 60) / 10), 4'(secs % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            chk("model_cycle", {17'd0, time_bcd, running, done, expired},
                {17'd0, to_bcd(m_secs), m_mode == 1, m_mode == 3, m_exp});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_load(input logic [11:0] v);
        load = 1'b1; load_bcd = v; cyc(1); load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1; cyc(1); pause = 1'b0;
    endtask

    task automatic do_ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; cyc(1); tick = 1'b0;
            if (gap > 1) cyc(gap - 1);
        end
    endtask

    initial begin
        cyc(2);
        chk("reset_state", {time_bcd, running, done, expired}, 15'h0);
        reset = 1'b0;
        cyc(1);

        // 0:05 countdown to expiry
        do_load(12'h005);
        do_start();
        chk("run_after_start", {31'd0, running}, 32'd1);
        do_ticks(60, 10);
        chk("five_to_four", {20'd0, time_bcd}, 32'h004);
        do_ticks(239, 10);
        chk("one_before_end", {20'd0, time_bcd, expired}, {20'd0, 12'h001, 1'b0});
        do_ticks(1, 1);
        chk("expire_edge", {time_bcd, running, done, expired}, {12'h000, 3'b011});
        cyc(1);
        chk("expire_one_cycle", {31'd0, expired}, 32'd0);
        chk("done_sticky", {31'd0, done}, 32'd1);
        do_ticks(5, 2);
        do_start();
        chk("done_ignores", {time_bcd, running, done}, {12'h000, 2'b01});

        // Borrow paths
        do_load(12'h100);
        chk("load_clears_done", {31'd0, done}, 32'd0);
        do_start();
        do_ticks(60, 2);
        chk("minute_borrow", {20'd0, time_bcd}, 32'h059);
        do_load(12'h010);
        do_start();
        do_ticks(60, 2);
        chk("tens_borrow", {20'd0, time_bcd}, 32'h009);

        // Pause holds sub count
        do_load(12'h002);
        do_start();
        do_ticks(30, 2);
        do_pause();
        do_ticks(100, 1);
        chk("paused_hold", {20'd0, time_bcd, running}, {20'd0, 12'h002, 1'b0});
        do_start();
        do_ticks(29, 2);
        chk("resume_29", {20'd0, time_bcd}, 32'h002);
        do_ticks(1, 2);
        chk("resume_30", {20'd0, time_bcd}, 32'h001);

        // Clamp and zero start
        do_load(12'hFFF);
        chk("clamp_fff", {20'd0, time_bcd}, 32'h959);
        do_load(12'h0A7);
        chk("clamp_tens", {20'd0, time_bcd}, 32'h057);
        do_load(12'h000);
        do_start();
        chk("zero_start", {31'd0, running}, 32'd0);

        // Load beats tick at sub = 59
        do_load(12'h002);
        do_start();
        do_ticks(59, 1);
        load = 1'b1; load_bcd = 12'h030; tick = 1'b1;
        cyc(1);
        load = 1'b0; tick = 1'b0;
        chk("load_over_tick", {20'd0, time_bcd, running}, {20'd0, 12'h030, 1'b0});
        do_start();
        do_ticks(59, 1);
        chk("sub_cleared", {20'd0, time_bcd}, 32'h030);
        do_ticks(1, 1);
        chk("sub_cleared_next", {20'd0, time_bcd}, 32'h029);

        // Asynchronous reset mid-run
        do_load(12'h100);
        do_start();
        do_ticks(20, 1);
        #3 reset = 1'b1;
        #1 chk("async_reset", {time_bcd, running, done, expired}, 15'h0);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;
        do_ticks(70, 1);
        chk("ticks_after_reset", {20'd0, time_bcd, running}, 32'd0);
        do_load(12'h001);
        do_start();
        do_ticks(60, 1);
        chk("post_reset_expire", {time_bcd, running, done, expired}, {12'h000, 3'b011});
        cyc(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
